// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-bit signed multiply / divide unit for the CPU HI/LO path.
//   A multiply runs 32 radix-2 Booth steps and a divide runs 32
//   restoring-division steps on the operand magnitudes, one step per clock.
//   One sign-correction cycle follows, and then hi/lo are written and done
//   pulses for one cycle. A divide by zero skips the iterations: it flags
//   div_zero and pulses done on the next cycle, leaving hi/lo untouched.
//
// Ports
//   clock     rising-edge clock
//   reset     synchronous, active-low reset
//   start     request pulse; sampled only while idle
//   op        0 = signed multiply, 1 = signed divide
//   a         multiplicand / dividend
//   b         multiplier / divisor
//   hi        product[63:32] or remainder
//   lo        product[31:0] or quotient
//   busy      high while iterating or correcting signs
//   done      one-cycle completion pulse; hi/lo valid in that cycle
//   div_zero  set by a divide with b == 0, cleared by the next accepted start

module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operation context captured at acceptance
  logic               op_r;
  logic signed [31:0] a_r;
  logic               b_neg;
  logic [4:0]         cnt;

  // Booth register: {acc[31:0], multiplier[31:0], q-1}
  logic [64:0] booth_r;
  logic [64:0] booth_nxt;

  // Restoring divider: partial remainder, quotient/dividend shift, |divisor|
  logic [31:0] rem_r;
  logic [31:0] quot_r;
  logic [31:0] dvs_r;
  logic [31:0] rem_nxt;
  logic [31:0] quot_nxt;

  logic        is_div_zero;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  // Two's-complement negate when n is set
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of a signed word as an unsigned value (0x80000000 maps to itself)
  function automatic logic [31:0] mag(input logic [31:0] v);
    return neg_if(v, v[31]);
  endfunction

  assign is_div_zero = op && (b == 32'd0);

  // ---------------------------------------------------------------------------
  // Booth step. The add/subtract is done at 33 bits so that the shifted-in
  // sign is the true sign of the partial sum; this keeps the most negative
  // multiplicand (0x80000000) correct.
  // ---------------------------------------------------------------------------
  logic signed [32:0] acc_ext;
  logic signed [32:0] mcand_ext;
  logic signed [32:0] booth_sum;

  always_comb begin
    acc_ext   = {booth_r[64], booth_r[64:33]};
    mcand_ext = {a_r[31], a_r};
    case (booth_r[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
    // Arithmetic right shift of the 66-bit {sum, multiplier, q-1} back to 65
    booth_nxt = {booth_sum, booth_r[32:1]};
  end

  // ---------------------------------------------------------------------------
  // Restoring division step on magnitudes
  // ---------------------------------------------------------------------------
  logic [32:0] rem_shift;
  logic        rem_ge;

  always_comb begin
    rem_shift = {rem_r, quot_r[31]};
    rem_ge    = (rem_shift >= {1'b0, dvs_r});
    rem_nxt   = rem_ge ? (rem_shift[31:0] - dvs_r) : rem_shift[31:0];
    quot_nxt  = {quot_r[30:0], rem_ge};
  end

  // ---------------------------------------------------------------------------
  // Sign correction: quotient negative when operand signs differ, remainder
  // takes the sign of the dividend. Multiply results pass straight through.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (op_r) begin
      fix_hi = neg_if(rem_r, a_r[31]);
      fix_lo = neg_if(quot_r, a_r[31] ^ b_neg);
    end else begin
      fix_hi = booth_r[64:33];
      fix_lo = booth_r[32:1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = is_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // cnt == 31 means this edge performs the 32nd iteration
        if (cnt == 5'd31) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      op_r     <= 1'b0;
      a_r      <= '0;
      b_neg    <= 1'b0;
      cnt      <= '0;
      booth_r  <= '0;
      rem_r    <= '0;
      quot_r   <= '0;
      dvs_r    <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            a_r      <= a;
            b_neg    <= b[31];
            cnt      <= '0;
            booth_r  <= {32'd0, b, 1'b0};
            rem_r    <= '0;
            quot_r   <= mag(a);
            dvs_r    <= mag(b);
            div_zero <= is_div_zero;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_r) begin
            rem_r  <= rem_nxt;
            quot_r <= quot_nxt;
          end else begin
            booth_r <= booth_nxt;
          end
        end
        FIX: begin
          // The only edge that updates hi/lo is the one entering DONE
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, using the port names clock and reset.
REQ-003 clock  input  1  rising-edge clock shared with the CPU datapath.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 op  input  1  operation select: 0 = signed multiply (mult), 1 = signed divide (div).
REQ-007 a  input  32  operand A: multiplicand or dividend, driven from register A.
REQ-008 b  input  32  operand B: multiplier or divisor, driven from register B.
REQ-009 hi  output  32  HI register: high product word, or remainder.
REQ-010 lo  output  32  LO register: low product word, or quotient.
REQ-011 busy  output  1  high while an operation is in flight (RUN or FIX).
REQ-012 done  output  1  one-cycle pulse marking completion; hi and lo are valid in the same cycle.
REQ-013 div_zero  output  1  registered flag; set by a div with b == 0, cleared by the next accepted start.

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN, FIX and DONE; its encoding is free.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and op, clear the iteration counter, clear div_zero and go to RUN; when op=1 and b==0 it SHALL instead set div_zero and go to DONE.
REQ-016 start SHALL be ignored in RUN, FIX and DONE; operands SHALL be read only at acceptance.
REQ-017 For op=0, RUN SHALL perform 32 radix-2 Booth iterations, one per cycle, on a 65-bit {acc, multiplier, q-1} register with arithmetic right shift.
REQ-018 For op=1, RUN SHALL perform 32 restoring-division iterations, one per cycle, on the magnitudes |a| and |b| treated as unsigned 32-bit values.
REQ-019 After 32 iterations the block SHALL spend one FIX cycle on sign correction:
- quotient negated when sign(a) XOR sign(b) = 1;
- remainder given the sign of a;
- mult needs no correction.
REQ-020 The block SHALL write hi and lo only on the edge entering DONE; at all other times they SHALL hold their value.
REQ-021 For mult, hi and lo SHALL hold product[63:32] and product[31:0] of the signed 64-bit product.
REQ-022 For div, lo SHALL hold the quotient truncated toward zero, and hi SHALL hold a - lo*b.
REQ-023 Latency SHALL be fixed: start accepted at edge k, then done=1 in the cycle following edge k+34 for both mult and div.
REQ-024 For div by zero, done=1 SHALL occur in the cycle following edge k+1, with hi and lo unchanged and div_zero=1.
REQ-025 busy SHALL be 1 exactly in RUN and FIX, and 0 in IDLE and DONE.
REQ-026 DONE SHALL return to IDLE unconditionally after one cycle; a start asserted during DONE SHALL be ignored.
REQ-027 div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no trap.
REQ-028 mult 0x80000000 * 0x80000000 SHALL give hi=0x40000000 and lo=0x00000000.

Reset
REQ-029 reset=0 at a rising edge SHALL force the following, regardless of state, including mid-RUN or mid-FIX:
- state IDLE;
- hi, lo, the counter and the internal registers all 0;
- busy, done and div_zero all 0.
REQ-030 The first start SHALL be accepted no earlier than the first edge with reset=1.

Verification
REQ-031 The bench SHALL check that start with op=0, a=7, b=0xFFFFFFFD gives done in the cycle after edge k+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB, and busy high for exactly 33 cycles.
REQ-032 The bench SHALL check that op=1, a=0xFFFFFFF9 (-7), b=2 gives lo=0xFFFFFFFD and hi=0xFFFFFFFF, and that op=1, a=7, b=0xFFFFFFFE gives lo=0xFFFFFFFD and hi=0x00000001.
REQ-033 The bench SHALL check that op=1, a=5, b=0 with prior hi=lo=0x12345678 gives done in the cycle after edge k+1, div_zero=1, hi and lo unchanged, and div_zero=0 after the next start.
REQ-034 The bench SHALL check the corner cases of REQ-027 and REQ-028 with exact values.
REQ-035 The bench SHALL check that start pulsed at RUN cycle 5 with different operands leaves the result equal to the first operation's result and produces only one done pulse.
REQ-036 The bench SHALL check that reset=0 at RUN cycle 10 gives busy=0, done=0 and hi=lo=0 on the next edge, that no done pulse follows, and that a fresh mult then completes correctly.
